psum_collector: RTL and testbench

PSUM_COLLECTOR -- requirements
Module: psum_collector

---
 rtl/psum_collector_pkg.sv | 55 +++++
 rtl/psum_collector_if.sv | 43 ++++
 rtl/psum_collector_ram.sv | 45 ++++
 rtl/psum_collector.sv | 248 ++++++++++++++++++++++++
 tb/tb_psum_collector.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/psum_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : psum_collector_pkg
//  Purpose  : Shared definitions for the partial-sum collector: FSM state
//             encoding, info-field last-pass flag position and the per-lane
//             signed saturating adder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package psum_collector_pkg;

  // Collector FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The last-pass flag sits this many bits below the info field width,
  // i.e. it is the MSB of the info field.
  localparam int unsigned c_LASTPASS_FROM_MSB = 1;

  // Working width of the saturating adder; lanes are sign-extended into it.
  // Lane width must be strictly less than this.
  localparam int unsigned c_SAT_W = 32;

  function automatic int unsigned lastpass_bit(input int unsigned infow);
    return infow - c_LASTPASS_FROM_MSB;
  endfunction

  // Signed add of two sign-extended lanes, clamped to the range of an
  // ow-bit two's-complement number. Caller keeps the low ow bits.
  function automatic logic signed [c_SAT_W-1:0] sat_add(
    input logic signed [c_SAT_W-1:0] a,
    input logic signed [c_SAT_W-1:0] b,
    input int unsigned               ow
  );
    logic signed [c_SAT_W:0] s;
    logic signed [c_SAT_W:0] hi;
    logic signed [c_SAT_W:0] lo;
    logic signed [c_SAT_W:0] one;
    one = {{c_SAT_W{1'b0}}, 1'b1};
    s   = {a[c_SAT_W-1], a} + {b[c_SAT_W-1], b};
    hi  = (one <<< (ow - 1)) - one;
    lo  = -hi - one;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s[c_SAT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : psum_collector_if
//  Purpose  : Bundles the upstream partial-sum stream (s2_*), the downstream
//             drain stream (m_*) and the status flags of the collector.
//  Modports : master - upstream/downstream environment (drives s2_*, m_ready)
//             slave  - the collector (drives m_data/m_valid/m_last/busy/err)
//  Revision : 1.0  initial release
// ============================================================================
interface psum_collector_if #(
  parameter int OW     = 22,
  parameter int COLUMN = 6,
  parameter int INFOW2 = 28
);
  localparam int c_DW = OW * COLUMN;

  logic [c_DW-1:0]   s2_data;
  logic [INFOW2-1:0] s2_info;
  logic              s2_valid;
  logic              s2_valid_pre;
  logic              s2_first;
  logic [9:0]        s2_base;
  logic [9:0]        s2_size;
  logic [c_DW-1:0]   m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              err;

  modport master (
    output s2_data, s2_info, s2_valid, s2_valid_pre, s2_first, s2_base,
           s2_size, m_ready,
    input  m_data, m_valid, m_last, busy, err
  );

  modport slave (
    input  s2_data, s2_info, s2_valid, s2_valid_pre, s2_first, s2_base,
           s2_size, m_ready,
    output m_data, m_valid, m_last, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/psum_collector_ram.sv
`default_nettype none
// ============================================================================
//  Module   : psum_ram
//  Purpose  : Simple dual-port accumulation buffer, 2^AW words of DW bits.
//             One write port, one read port, 1-cycle registered read.
//             A read hitting the address being written in the same cycle
//             returns the new data (write-first).
//  Ports    : clk      - clock
//             i_we     - write enable      i_waddr / i_wdata - write port
//             i_re     - read enable       i_raddr           - read address
//             o_rdata  - read data, valid the cycle after i_re
//  Revision : 1.0  initial release
// ============================================================================
module psum_ram #(
  parameter int AW = 10,
  parameter int DW = 132
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Bypass keeps read-modify-write correct for back-to-back bursts that
  // touch the same word on consecutive beats.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/psum_collector.sv
`default_nettype none
// ============================================================================
//  Module   : psum_collector
//  Purpose  : Accumulates bursts of COLUMN-lane partial sums into a buffer
//             (overwrite on first pass, saturating add otherwise) and, after
//             a last-pass burst, drains that burst's locations downstream
//             with valid/ready flow control.
//  Ports    : clk    - clock
//             rst    - synchronous active-high reset
//             io_bus - psum_collector_if.slave: s2_* beat stream in,
//                      m_* drain stream out, busy/err status out
//  Revision : 1.0  initial release
// ============================================================================
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int OW     = 22,
  parameter int COLUMN = 6,
  parameter int INFOW2 = 28,
  parameter int AW     = 10
) (
  input wire logic         clk,
  input wire logic         rst,
  psum_collector_if.slave  io_bus
);
  localparam int          c_DW     = OW * COLUMN;
  localparam int unsigned c_LP_BIT = lastpass_bit(INFOW2);

  state_t          r_state;

  // burst context latched on burst start
  logic [9:0]      r_cnt;
  logic [9:0]      r_base;
  logic [9:0]      r_size;
  logic            r_first;
  logic            r_lp;

  // per-beat context carried from the valid_pre cycle to the valid cycle;
  // needed because a back-to-back burst relatches r_* while the previous
  // burst's last beat is still being written
  logic            r_p1_vld;
  logic [AW-1:0]   r_p1_addr;
  logic            r_p1_first;
  logic            r_p1_last;
  logic            r_p1_lp;
  logic [9:0]      r_p1_base;
  logic [9:0]      r_p1_size;

  // drain
  logic [AW-1:0]   r_drn_addr;
  logic [9:0]      r_drn_cnt;
  logic [9:0]      r_drn_size;
  logic            r_rd_pend;
  logic            r_pend_last;

  // registered outputs
  logic [c_DW-1:0] r_m_data;
  logic            r_m_valid;
  logic            r_m_last;
  logic            r_busy;
  logic            r_err;

  logic            w_is_drain;
  logic            w_lp_end;
  logic            w_can_take;
  logic            w_start;
  logic            w_size0;
  logic            w_take;
  logic [9:0]      w_cur_base;
  logic [9:0]      w_cur_size;
  logic            w_cur_first;
  logic            w_cur_lp;
  logic [9:0]      w_cnt_inc;
  logic            w_beat_last;
  logic [AW-1:0]   w_acc_addr;
  logic            w_we;
  logic            w_burst_end;
  logic            w_drn_rd;
  logic            w_re;
  logic [AW-1:0]   w_raddr;
  logic [c_DW-1:0] w_rdata;
  logic [c_DW-1:0] w_wdata;
  logic            w_info_unused;

  assign w_is_drain  = (r_state == ST_DRAIN);
  // Last beat of a last-pass burst: a new burst starting in this very cycle
  // cannot be served because the collector is about to drain.
  assign w_lp_end    = io_bus.s2_valid && r_p1_vld && r_p1_last && r_p1_lp;
  assign w_can_take  = io_bus.s2_valid_pre && !w_is_drain && !w_lp_end;
  assign w_start     = w_can_take && (r_cnt == 10'd0);
  assign w_size0     = w_start && (io_bus.s2_size == 10'd0);
  assign w_take      = w_can_take && !w_size0;

  // On the start cycle the burst fields come straight from the bus
  assign w_cur_base  = (r_cnt == 10'd0) ? io_bus.s2_base           : r_base;
  assign w_cur_size  = (r_cnt == 10'd0) ? io_bus.s2_size           : r_size;
  assign w_cur_first = (r_cnt == 10'd0) ? io_bus.s2_first          : r_first;
  assign w_cur_lp    = (r_cnt == 10'd0) ? io_bus.s2_info[c_LP_BIT] : r_lp;

  assign w_cnt_inc   = r_cnt + 10'd1;
  assign w_beat_last = (w_cnt_inc == w_cur_size);
  assign w_acc_addr  = AW'(w_cur_base) + AW'(r_cnt);

  assign w_we        = io_bus.s2_valid && r_p1_vld;
  assign w_burst_end = w_we && r_p1_last;

  // Drain read: first read on entry, then one read per handshake of a
  // non-final beat, so the next word arrives while the bus is idle.
  assign w_drn_rd    = w_is_drain &&
                       ((!r_m_valid && !r_rd_pend) ||
                        (r_m_valid && io_bus.m_ready && !r_m_last));
  assign w_re        = w_take || w_drn_rd;
  assign w_raddr     = w_is_drain ? r_drn_addr : w_acc_addr;

  assign w_info_unused = ^io_bus.s2_info[INFOW2-2:0];

  for (genvar l = 0; l < COLUMN; l++) begin : g_lane
    logic signed [c_SAT_W-1:0]    w_a;
    logic signed [c_SAT_W-1:0]    w_b;
    logic signed [c_SAT_W-1:0]    w_s;
    logic [c_SAT_W-OW-1:0]        w_sum_hi_unused;

    assign w_a = c_SAT_W'($signed(w_rdata[l*OW +: OW]));
    assign w_b = c_SAT_W'($signed(io_bus.s2_data[l*OW +: OW]));
    assign w_s = sat_add(w_a, w_b, OW);
    assign w_sum_hi_unused = w_s[c_SAT_W-1:OW];
    assign w_wdata[l*OW +: OW] = r_p1_first ? io_bus.s2_data[l*OW +: OW]
                                            : w_s[OW-1:0];
  end

  psum_ram #(
    .AW (AW),
    .DW (c_DW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_p1_addr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_size      <= '0;
      r_first     <= 1'b0;
      r_lp        <= 1'b0;
      r_p1_vld    <= 1'b0;
      r_p1_addr   <= '0;
      r_p1_first  <= 1'b0;
      r_p1_last   <= 1'b0;
      r_p1_lp     <= 1'b0;
      r_p1_base   <= '0;
      r_p1_size   <= '0;
      r_drn_addr  <= '0;
      r_drn_cnt   <= '0;
      r_drn_size  <= '0;
      r_rd_pend   <= 1'b0;
      r_pend_last <= 1'b0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_take) begin
        r_cnt <= w_beat_last ? 10'd0 : w_cnt_inc;
        if (r_cnt == 10'd0) begin
          r_base  <= io_bus.s2_base;
          r_size  <= io_bus.s2_size;
          r_first <= io_bus.s2_first;
          r_lp    <= io_bus.s2_info[c_LP_BIT];
        end
      end

      r_p1_vld   <= w_take;
      r_p1_addr  <= w_acc_addr;
      r_p1_first <= w_cur_first;
      r_p1_last  <= w_beat_last;
      r_p1_lp    <= w_cur_lp;
      r_p1_base  <= w_cur_base;
      r_p1_size  <= w_cur_size;

      if ((io_bus.s2_valid && w_is_drain) || w_size0) begin
        r_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state <= ST_ACC;
          end
        end

        ST_ACC: begin
          if (w_burst_end) begin
            if (r_p1_lp) begin
              r_state    <= ST_DRAIN;
              r_busy     <= 1'b1;
              r_drn_addr <= AW'(r_p1_base);
              r_drn_cnt  <= 10'd0;
              r_drn_size <= r_p1_size;
            end else if (!w_take) begin
              r_state <= ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          if (r_rd_pend) begin
            r_m_data  <= w_rdata;
            r_m_valid <= 1'b1;
            r_m_last  <= r_pend_last;
            r_rd_pend <= 1'b0;
          end
          if (r_m_valid && io_bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_m_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          if (w_drn_rd) begin
            r_drn_addr  <= r_drn_addr + AW'(1);
            r_drn_cnt   <= r_drn_cnt + 10'd1;
            r_rd_pend   <= 1'b1;
            r_pend_last <= (r_drn_cnt == (r_drn_size - 10'd1));
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.m_data  = r_m_data;
  assign io_bus.m_valid = r_m_valid;
  assign io_bus.m_last  = r_m_last;
  assign io_bus.busy    = r_busy;
  assign io_bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_psum_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_collector
//  Purpose  : Directed self-checking bench for psum_collector: overwrite and
//             accumulate passes, saturation, address wrap, same-address
//             bypass, drain backpressure, err flag and mid-drain reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psum_collector;
  localparam int OW     = 22;
  localparam int COLUMN = 6;
  localparam int INFOW2 = 28;
  localparam int AW     = 10;
  localparam int DW     = OW * COLUMN;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  psum_collector_if #(.OW(OW), .COLUMN(COLUMN), .INFOW2(INFOW2)) bus ();

  psum_collector #(
    .OW     (OW),
    .COLUMN (COLUMN),
    .INFOW2 (INFOW2),
    .AW     (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // beat table consumed by play(): one entry per valid_pre cycle
  logic [9:0]    e_base  [0:7];
  logic [9:0]    e_size  [0:7];
  logic          e_first [0:7];
  logic          e_lp    [0:7];
  logic [DW-1:0] e_data  [0:7];

  function automatic logic [DW-1:0] mk(input int a, input int step);
    logic [DW-1:0] d;
    for (int l = 0; l < COLUMN; l++) d[l*OW +: OW] = OW'(a + l * step);
    return d;
  endfunction

  function automatic logic [DW-1:0] mk6(input int v0, input int v1, input int v2,
                                        input int v3, input int v4, input int v5);
    logic [DW-1:0] d;
    d[0*OW +: OW] = OW'(v0);
    d[1*OW +: OW] = OW'(v1);
    d[2*OW +: OW] = OW'(v2);
    d[3*OW +: OW] = OW'(v3);
    d[4*OW +: OW] = OW'(v4);
    d[5*OW +: OW] = OW'(v5);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_e(input int i, input int base, input int size, input logic first,
                       input logic lp, input logic [DW-1:0] data);
    e_base[i]  = 10'(base);
    e_size[i]  = 10'(size);
    e_first[i] = first;
    e_lp[i]    = lp;
    e_data[i]  = data;
  endtask

  // Drive n valid_pre cycles back to back, each s2_valid one cycle later.
  task automatic play(input int n);
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c < n) begin
        bus.s2_valid_pre = 1'b1;
        bus.s2_base      = e_base[c];
        bus.s2_size      = e_size[c];
        bus.s2_first     = e_first[c];
        bus.s2_info      = {e_lp[c], 27'h0000ABC};
      end else begin
        bus.s2_valid_pre = 1'b0;
      end
      if (c >= 1) begin
        bus.s2_valid = 1'b1;
        bus.s2_data  = e_data[c-1];
      end else begin
        bus.s2_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.s2_valid = 1'b0;
  endtask

  // Wait (bounded) for a drain beat, check it, let it handshake.
  task automatic get_beat(input string tag, input logic [DW-1:0] exp_d, input logic exp_l);
    int n;
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, DW'(bus.m_valid), DW'(1'b1));
    chk({tag, "_data"}, bus.m_data, exp_d);
    chk({tag, "_last"}, DW'(bus.m_last), DW'(exp_l));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.s2_data      = '0;
    bus.s2_info      = '0;
    bus.s2_valid     = 1'b0;
    bus.s2_valid_pre = 1'b0;
    bus.s2_first     = 1'b0;
    bus.s2_base      = '0;
    bus.s2_size      = '0;
    bus.m_ready      = 1'b1;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_m_valid", DW'(bus.m_valid), '0);
    chk("rst_m_last",  DW'(bus.m_last),  '0);
    chk("rst_busy",    DW'(bus.busy),    '0);
    chk("rst_err",     DW'(bus.err),     '0);
    chk("rst_m_data",  bus.m_data,       '0);
    rst = 1'b0;

    // ---- first pass at base 5, then last-pass +10 -> drain 11..13
    for (int j = 0; j < 3; j++) set_e(j, 5, 3, 1'b1, 1'b0, mk(1 + j, 100));
    play(3);
    chk("a_busy_after_first", DW'(bus.busy), '0);
    for (int j = 0; j < 3; j++) set_e(j, 5, 3, 1'b0, 1'b1, mk(10, 0));
    play(3);
    chk("a_busy_drain", DW'(bus.busy), DW'(1'b1));
    get_beat("a_b0", mk(11, 100), 1'b0);
    get_beat("a_b1", mk(12, 100), 1'b0);
    get_beat("a_b2", mk(13, 100), 1'b1);
    chk("a_busy_done", DW'(bus.busy), '0);

    // ---- saturation at both rails
    set_e(0, 100, 1, 1'b1, 1'b0, mk6(2097000, -2097000, 2097151, -5, 0, 100));
    play(1);
    set_e(0, 100, 1, 1'b0, 1'b1, mk6(1000, -1000, -1, -7, -2097152, 51));
    play(1);
    get_beat("sat", mk6(2097151, -2097152, 2097150, -12, -2097152, 151), 1'b1);

    // ---- address wrap 1022,1023,0,1
    for (int j = 0; j < 4; j++) set_e(j, 1022, 4, 1'b1, 1'b0, mk(1000 + j, 1));
    play(4);
    for (int j = 0; j < 4; j++) set_e(j, 1022, 4, 1'b0, 1'b1, mk(1, 0));
    play(4);
    for (int j = 0; j < 4; j++) get_beat($sformatf("wrap_b%0d", j), mk(1001 + j, 1), j == 3);

    // ---- back-to-back size-1 bursts on the same word: 3 then +7
    set_e(0, 0, 1, 1'b1, 1'b0, mk(3, 0));
    set_e(1, 0, 1, 1'b0, 1'b1, mk(7, 0));
    play(2);
    chk("b2b_busy", DW'(bus.busy), DW'(1'b1));
    get_beat("b2b", mk(10, 0), 1'b1);

    // ---- drain backpressure with a stray s2 beat
    bus.m_ready = 1'b0;
    for (int j = 0; j < 2; j++) set_e(j, 200, 2, 1'b1, 1'b1, mk(40 + j, 2));
    play(2);
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_valid_%0d", k), DW'(bus.m_valid), DW'(1'b1));
      chk($sformatf("stall_data_%0d", k), bus.m_data, mk(40, 2));
      chk($sformatf("stall_last_%0d", k), DW'(bus.m_last), '0);
      bus.s2_valid = (k == 1);
      bus.s2_data  = mk(999, 0);
      @(negedge clk);
    end
    bus.s2_valid = 1'b0;
    chk("stall_err", DW'(bus.err), DW'(1'b1));
    bus.m_ready = 1'b1;
    get_beat("stall_b0", mk(40, 2), 1'b0);
    get_beat("stall_b1", mk(41, 2), 1'b1);
    chk("stall_err_sticky", DW'(bus.err), DW'(1'b1));
    chk("stall_busy_done", DW'(bus.busy), '0);

    // ---- reset in the middle of a drain
    bus.m_ready = 1'b0;
    for (int j = 0; j < 3; j++) set_e(j, 300, 3, 1'b1, 1'b1, mk(5, 1));
    play(3);
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pre_valid", DW'(bus.m_valid), DW'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    chk("mid_m_valid", DW'(bus.m_valid), '0);
    chk("mid_busy",    DW'(bus.busy),    '0);
    chk("mid_err",     DW'(bus.err),     '0);
    chk("mid_m_last",  DW'(bus.m_last),  '0);
    repeat (3) @(negedge clk);
    chk("mid_idle_valid", DW'(bus.m_valid), '0);

    // ---- zero-size burst start flags err
    set_e(0, 10, 0, 1'b1, 1'b0, mk(1, 0));
    play(1);
    chk("size0_err",  DW'(bus.err),  DW'(1'b1));
    chk("size0_busy", DW'(bus.busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
